reg_writeback: RTL and testbench

- Producer side of the register file write port.
- Merges ALU results and load responses from the memory stage into one registered write stream (write_en/write_addr/write_data) that feeds the register file.
- Buffers formatted load data in a small FIFO.
- Keeps a per-register pending-load scoreboard so issue logic can detect load-use and write-after-write hazards.

---
 rtl/reg_writeback.sv | 194 +++++++++++++++++++
 tb/tb_reg_writeback.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: producer side of the register file write port.
//
// Merges ALU results and load responses into one registered write stream.
// Load responses are formatted (byte/half extraction and extension) and
// buffered in a small FIFO. A per-register pending-load scoreboard lets the
// issue logic detect load-use and write-after-write hazards.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU result (no handshake)
//   alu_stall                     upstream must hold ALU results (FIFO full)
//   ld_valid/ld_ready             load response handshake
//   ld_rd/ld_data/ld_funct3/ld_off  load destination, raw word, type, byte offset
//   issue_load_en/issue_load_rd   load issue notification (sets pending bit)
//   rs1/rs2                       hazard query addresses
//   hazard1/hazard2/hazard_rd     combinational hazard flags
//   write_en/write_addr/write_data  registered register file write port
//   err                           sticky: ALU result dropped while FIFO full
module reg_writeback #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic            issue_load_en,
  input  logic [AW-1:0]   issue_load_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            hazard_rd,
  output logic            write_en,
  output logic [AW-1:0]   write_addr,
  output logic [XLEN-1:0] write_data,
  output logic            err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // FIFO storage: destination register and formatted data per entry
  logic [AW-1:0]   fifo_rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            alu_ok;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;

  logic            write_en_reg, write_en_next;
  logic [AW-1:0]   write_addr_reg, write_addr_next;
  logic [XLEN-1:0] write_data_reg, write_data_next;
  logic            err_reg, err_next;

  logic [REG_COUNT-1:0] pending_reg;

  // Readiness comes from registered occupancy only, so a same-cycle pop
  // never opens the door combinationally.
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign ld_ready   = !fifo_full;
  assign alu_stall  = fifo_full;

  // Responses to x0 are consumed (ld_ready still high) but never stored.
  assign push    = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_ok  = alu_valid && (alu_rd != '0);
  assign head_rd   = fifo_rd_mem[rd_ptr_reg];
  assign head_data = fifo_data_mem[rd_ptr_reg];

  // Load data formatting
  always_comb begin
    ld_byte = ld_data[{ld_off, 3'b000} +: 8];
    ld_half = ld_data[{ld_off[1], 4'b0000} +: 16];
    case (ld_funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = ld_data;
    endcase
  end

  // Write selection. A full FIFO takes priority over the ALU so loads can
  // always drain; an ALU result arriving then is lost and flagged.
  always_comb begin
    pop             = 1'b0;
    write_en_next   = 1'b0;
    write_addr_next = write_addr_reg;
    write_data_next = write_data_reg;
    err_next        = err_reg;
    if (fifo_full) begin
      pop             = 1'b1;
      write_en_next   = 1'b1;
      write_addr_next = head_rd;
      write_data_next = head_data;
      if (alu_ok) begin
        err_next = 1'b1;
      end
    end else if (alu_ok) begin
      write_en_next   = 1'b1;
      write_addr_next = alu_rd;
      write_data_next = alu_data;
    end else if (!fifo_empty) begin
      pop             = 1'b1;
      write_en_next   = 1'b1;
      write_addr_next = head_rd;
      write_data_next = head_data;
    end
  end

  // FIFO storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= ld_rd;
      fifo_data_mem[wr_ptr_reg] <= ld_fmt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
      write_en_reg   <= write_en_next;
      write_addr_reg <= write_addr_next;
      write_data_reg <= write_data_next;
      err_reg        <= err_next;
    end
  end

  // Pending-load scoreboard; x0 never pends. Set beats clear for the same rd.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending_reg[gi] = 1'b0;
      end else begin : g_bit
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pending_reg[gi] <= 1'b0;
          end else if (issue_load_en && (issue_load_rd == AW'(gi))) begin
            pending_reg[gi] <= 1'b1;
          end else if (pop && (head_rd == AW'(gi))) begin
            pending_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign hazard1    = pending_reg[rs1];
  assign hazard2    = pending_reg[rs2];
  assign hazard_rd  = issue_load_en && pending_reg[issue_load_rd];

  assign write_en   = write_en_reg;
  assign write_addr = write_addr_reg;
  assign write_data = write_data_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_off;
  logic            issue_load_en;
  logic [AW-1:0]   issue_load_rd;
  logic [AW-1:0]   rs1, rs2;
  logic            hazard1, hazard2, hazard_rd;
  logic            write_en;
  logic [AW-1:0]   write_addr;
  logic [XLEN-1:0] write_data;
  logic            err;

  reg_writeback #(.XLEN(32), .REG_COUNT(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_off(ld_off),
    .issue_load_en(issue_load_en), .issue_load_rd(issue_load_rd),
    .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2), .hazard_rd(hazard_rd),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vec_cnt = 0;
  int  miscmp_cnt = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && write_en) begin
      if (exp_q.size() == 0) begin
        check_value("unexp_wr", 32'(write_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write addr=%0d data=%h (expected addr=%0d data=%h)",
                 write_addr, write_data, e.addr, e.data);
        check_value("wr_addr", 32'(write_addr), 32'(e.addr));
        check_value("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0]  f3_tab  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
  logic [1:0]  off_tab [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [31:0] res_tab [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                               32'h000080FF, 32'h80FF7F01, 32'h80FF7F01};

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0; ld_funct3 = '0; ld_off = '0;
    issue_load_en = 0; issue_load_rd = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_value("rst_wen",   32'(write_en), 32'd0);
    check_value("rst_waddr", 32'(write_addr), 32'd0);
    check_value("rst_wdata", write_data, 32'd0);
    check_value("rst_err",   32'(err), 32'd0);
    check_value("rst_ready", 32'(ld_ready), 32'd1);
    check_value("rst_stall", 32'(alu_stall), 32'd0);

    // 1: single ALU write, one cycle latency
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    exp_push(5, 32'h0000_1234);
    step();
    alu_valid = 0;
    check_value("t1_wen", 32'(write_en), 32'd1);
    check_value("t1_addr", 32'(write_addr), 32'd5);
    step();
    check_value("t1_wen_off", 32'(write_en), 32'd0);
    check_value("t1_addr_hold", 32'(write_addr), 32'd5);

    // 2: load formatting and hazard lifetime
    for (int i = 0; i < 6; i++) begin
      issue_load_en = 1; issue_load_rd = 7; rs1 = 7;
      step();
      issue_load_en = 0;
      check_value("t2_haz_pend", 32'(hazard1), 32'd1);
      issue_load_en = 1;
      #1;
      check_value("t2_haz_rd", 32'(hazard_rd), 32'd1);
      issue_load_en = 0;
      ld_valid = 1; ld_rd = 7; ld_data = 32'h80FF7F01;
      ld_funct3 = f3_tab[i]; ld_off = off_tab[i];
      exp_push(7, res_tab[i]);
      step();
      ld_valid = 0;
      check_value("t2_no_bypass", 32'(write_en), 32'd0);
      check_value("t2_haz_buf", 32'(hazard1), 32'd1);
      step();
      check_value("t2_wen", 32'(write_en), 32'd1);
      check_value("t2_haz_clr", 32'(hazard1), 32'd0);
    end
    step();

    // 3: ALU priority over a buffered load
    issue_load_en = 1; issue_load_rd = 3; rs1 = 3;
    step();
    issue_load_en = 0;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_rd = 4; alu_data = 32'hA0 + 32'(k);
      exp_push(4, 32'hA0 + 32'(k));
      if (k == 0) begin
        ld_valid = 1; ld_rd = 3; ld_data = 32'h11223344; ld_funct3 = 3'b010; ld_off = 0;
      end
      step();
      ld_valid = 0;
    end
    alu_valid = 0;
    exp_push(3, 32'h11223344);
    check_value("t3_haz", 32'(hazard1), 32'd1);
    step();
    check_value("t3_ld_wen", 32'(write_en), 32'd1);
    check_value("t3_ld_addr", 32'(write_addr), 32'd3);
    step();
    check_value("t3_empty", 32'(write_en), 32'd0);

    // 4: fill FIFO under ALU pressure, then forced drain with ALU drop
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_rd = 10; alu_data = 32'hB0 + 32'(k);
      exp_push(10, 32'hB0 + 32'(k));
      ld_valid = 1; ld_rd = AW'(11 + k); ld_data = 32'hC0 + 32'(k); ld_funct3 = 3'b010;
      step();
    end
    ld_valid = 0;
    check_value("t4_ready", 32'(ld_ready), 32'd0);
    check_value("t4_stall", 32'(alu_stall), 32'd1);
    check_value("t4_err0", 32'(err), 32'd0);
    alu_data = 32'hDEAD;
    for (int k = 0; k < 4; k++) exp_push(AW'(11 + k), 32'hC0 + 32'(k));
    step();
    alu_valid = 0;
    check_value("t4_err1", 32'(err), 32'd1);
    check_value("t4_head", 32'(write_addr), 32'd11);
    check_value("t4_ready1", 32'(ld_ready), 32'd1);
    repeat (4) step();
    check_value("t4_err_sticky", 32'(err), 32'd1);

    // 5: x0 traffic is ignored
    issue_load_en = 1; issue_load_rd = 6; rs1 = 6;
    step();
    issue_load_en = 0;
    ld_valid = 1; ld_rd = 0; ld_data = 32'h5555; alu_valid = 1; alu_rd = 0; alu_data = 32'h6666;
    check_value("t5_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 0; alu_valid = 0;
    check_value("t5_wen", 32'(write_en), 32'd0);
    check_value("t5_pend", 32'(hazard1), 32'd1);
    step();
    check_value("t5_wen2", 32'(write_en), 32'd0);

    // 6: asynchronous reset with buffered loads
    issue_load_en = 1; issue_load_rd = 9; rs1 = 9;
    step();
    issue_load_en = 0;
    check_value("t6_pend", 32'(hazard1), 32'd1);
    for (int k = 0; k < 2; k++) begin
      alu_valid = 1; alu_rd = 20; alu_data = 32'hE0 + 32'(k);
      exp_push(20, 32'hE0 + 32'(k));
      ld_valid = 1; ld_rd = AW'(9 - k); ld_data = 32'hF0 + 32'(k); ld_funct3 = 3'b010;
      step();
    end
    ld_valid = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    alu_valid = 0;
    #1;
    check_value("t6_wen", 32'(write_en), 32'd0);
    check_value("t6_haz", 32'(hazard1), 32'd0);
    check_value("t6_err", 32'(err), 32'd0);
    issue_load_en = 1; issue_load_rd = 9;
    #1;
    check_value("t6_haz_rd", 32'(hazard_rd), 32'd0);
    issue_load_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_value("t6_no_wr", 32'(write_en), 32'd0);
    end
    check_value("t6_ready", 32'(ld_ready), 32'd1);

    #1;
    check_value("q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
